decode_stage: RTL
=================

Name: decode_stage

Overview:
- Instruction decode stage of the RV32i pipeline, sitting between the IF/ID register and the ID/EX register (idex_register).
- Holds the 32x32 architectural register file and performs write-back from W.
- Decodes Instr_D into the full control bundle, register addresses, read data and sign-extended immediate consumed by idex_register.

Parameters:
- REG_COUNT, 32, number of architectural registers (x0 hardwired to zero).
- XLEN, 32, data width.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; asynchronous, active-high.
- Instr_D  in  32  instruction from IF/ID.
- REG_W_En_W  in  1  write-back enable.
- RD_W  in  5  write-back destination.
- Result_W  in  32  write-back data.
- REG_W_En_D, MEM_W_En_D, Jump_En_D, Branch_En_D  out  1 each  control enables.
- MEM_Control_D  out  3  load/store width/sign (funct3).
- ALU_Control_D  out  4  ALU / compare operation.
- Branch_Src_Sel_D  out  1  target base: 0 = PC, 1 = rs1 (JALR).
- ALU_SrcA_Sel_D  out  1  0 = rs1, 1 = PC.
- ALU_SrcB_Sel_D  out  1  0 = rs2, 1 = immediate.
- Result_Src_Sel_D  out  2  00 = ALU, 01 = memory, 10 = PC+4.
- RD_D, RS1_D, RS2_D  out  5 each  Instr_D[11:7], [19:15], [24:20].
- REG_R_Data1_D, REG_R_Data2_D  out  32 each  register read data.
- Imm_Ext_D  out  32  sign-extended immediate.

Behaviour:
- Register file:
  - 31 physical 32-bit registers, x1..x31.
  - Asynchronous clear to 0 on RST, effective immediately, including mid-operation.
  - Write on posedge CLK when REG_W_En_W = 1, RST = 0 and RD_W != 0.
  - Writes to x0 are dropped. Reading x0 always returns 0.
- Reads are combinational.
- Internal write-through bypass: if REG_W_En_W = 1, RD_W != 0 and RD_W equals RS1_D or RS2_D, the corresponding read data returns Result_W in the same cycle. Both ports bypass independently.
- Decode is purely combinational from Instr_D (latency 0). Outputs are registered downstream by idex_register.
- ALU_Control encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT/BLT, 9 SLTU/BLTU, A PASS_B, B BEQ, C BNE, D BGE, E BGEU, F unused.
- Opcode map:
  - R-type (0110011): REG_W = 1, SrcB = 0, ALU from funct3 and funct7[5] (SUB/SRA).
  - I-ALU (0010011): REG_W = 1, SrcB = 1, I-imm. funct7[5] selects SRA only for funct3 = 101. SUB never decoded here.
  - LOAD (0000011): REG_W = 1, SrcB = 1, ADD, Result = 01, MEM_Control = funct3.
  - STORE (0100011): MEM_W = 1, SrcB = 1, ADD, S-imm, MEM_Control = funct3.
  - BRANCH (1100011): Branch_En = 1, SrcB = 0, ALU from funct3 compare code, B-imm, Branch_Src = 0.
  - JAL (1101111): Jump = 1, REG_W = 1, Result = 10, J-imm, Branch_Src = 0.
  - JALR (1100111): Jump = 1, REG_W = 1, Result = 10, I-imm, Branch_Src = 1.
  - LUI (0110111): REG_W = 1, SrcB = 1, PASS_B, U-imm.
  - AUIPC (0010111): REG_W = 1, SrcA = 1, SrcB = 1, ADD, U-imm.
- Illegal or unsupported opcode, or Instr_D = 0: all enables, selects and controls are 0 (NOP). Imm_Ext_D is 0.
- MEM_Control_D is 0 for every non-memory instruction.
- Immediate formats, with sign from Instr_D[31]:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'h0}.
  - J: {[31],[19:12],[20],[30:21],0}.
- RD_D, RS1_D and RS2_D are always the raw instruction fields, regardless of format.
- Reset values: no output is stored in this block. After RST, all register read data reads 0, and control outputs follow Instr_D.

Test Plan:
- Assert RST after writing x5 = 0xDEADBEEF; issue Instr_D = ADD x1,x5,x0 -> REG_R_Data1_D = 0 immediately on RST, REG_W_En_D = 1, ALU_Control_D = 0.
- Write x0 = 0x12345678, then read rs1 = x0 -> REG_R_Data1_D = 0. Write x7 = 0xA5A5A5A5, read next cycle -> 0xA5A5A5A5.
- Same cycle: REG_W_En_W = 1, RD_W = 3, Result_W = 0x55, Instr_D reads rs1 = rs2 = x3 -> both read ports = 0x55 (bypass).
- Instr_D = 0xFE010CE3 (BEQ x2,x0,-8) -> Branch_En_D = 1, ALU_Control_D = B, Imm_Ext_D = 0xFFFFFFF8, REG_W_En_D = 0.
- LW x4,-4(x2) = 0xFFC12203 -> Result_Src_Sel_D = 01, MEM_Control_D = 010, Imm_Ext_D = 0xFFFFFFFC. SW x4,8(x2) = 0x00412423 -> MEM_W_En_D = 1, Imm_Ext_D = 8.
- JALR x1,0(x6) = 0x000300E7 -> Jump_En_D = 1, Branch_Src_Sel_D = 1, Result_Src_Sel_D = 10. Opcode 1111111 -> all control outputs 0.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode with the architectural register file and W-stage write-back.
// Latency: decode and register reads are combinational (0 cycles); register writes land on posedge CLK.
// Backpressure: none in this block; stalls and flushes are applied by the IF/ID and ID/EX registers.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset (clears the register file)
//   Instr_D             instruction from IF/ID
//   REG_W_En_W/RD_W/Result_W  write-back port from W
//   *_En_D, *_Sel_D, MEM_Control_D, ALU_Control_D  decoded control bundle
//   RD_D/RS1_D/RS2_D    raw register fields; REG_R_Data1_D/2_D read data; Imm_Ext_D immediate
module decode_stage #(
  parameter int REG_COUNT = 32,
  parameter int XLEN      = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [31:0]     Instr_D,
  input  logic            REG_W_En_W,
  input  logic [4:0]      RD_W,
  input  logic [XLEN-1:0] Result_W,
  output logic            REG_W_En_D,
  output logic            MEM_W_En_D,
  output logic            Jump_En_D,
  output logic            Branch_En_D,
  output logic [2:0]      MEM_Control_D,
  output logic [3:0]      ALU_Control_D,
  output logic            Branch_Src_Sel_D,
  output logic            ALU_SrcA_Sel_D,
  output logic            ALU_SrcB_Sel_D,
  output logic [1:0]      Result_Src_Sel_D,
  output logic [4:0]      RD_D,
  output logic [4:0]      RS1_D,
  output logic [4:0]      RS2_D,
  output logic [XLEN-1:0] REG_R_Data1_D,
  output logic [XLEN-1:0] REG_R_Data2_D,
  output logic [XLEN-1:0] Imm_Ext_D
);

  localparam logic [3:0] ALU_ADD  = 4'h0, ALU_SUB  = 4'h1, ALU_AND  = 4'h2, ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4, ALU_SLL  = 4'h5, ALU_SRL  = 4'h6, ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SLT  = 4'h8, ALU_SLTU = 4'h9, ALU_PASS = 4'hA, ALU_BEQ  = 4'hB;
  localparam logic [3:0] ALU_BNE  = 4'hC, ALU_BGE  = 4'hD, ALU_BGEU = 4'hE;

  localparam logic [6:0] OP_R      = 7'b0110011, OP_I     = 7'b0010011, OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111, OP_LUI   = 7'b0110111, OP_AUIPC = 7'b0010111;

  // ---------------- register file (x0 has no storage) ----------------
  logic [XLEN-1:0] r_regs [1:REG_COUNT-1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 1; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else if (REG_W_En_W && (RD_W != 5'd0)) begin
      r_regs[RD_W] <= Result_W;
    end
  end

  logic [4:0] w_rs1, w_rs2;
  logic       w_byp1, w_byp2;

  assign w_rs1 = Instr_D[19:15];
  assign w_rs2 = Instr_D[24:20];
  assign RD_D  = Instr_D[11:7];
  assign RS1_D = w_rs1;
  assign RS2_D = w_rs2;

  // Write-through: a register being written this cycle is visible to the reader
  // in the same cycle. Suppressed during reset so reads are all-zero then.
  assign w_byp1 = !RST && REG_W_En_W && (RD_W != 5'd0) && (RD_W == w_rs1);
  assign w_byp2 = !RST && REG_W_En_W && (RD_W != 5'd0) && (RD_W == w_rs2);

  assign REG_R_Data1_D = (w_rs1 == 5'd0) ? '0 : w_byp1 ? Result_W : r_regs[w_rs1];
  assign REG_R_Data2_D = (w_rs2 == 5'd0) ? '0 : w_byp2 ? Result_W : r_regs[w_rs2];

  // ---------------- decode ----------------
  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_f7b5;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  assign w_op   = Instr_D[6:0];
  assign w_f3   = Instr_D[14:12];
  assign w_f7b5 = Instr_D[30];

  assign w_imm_i = {{(XLEN-12){Instr_D[31]}}, Instr_D[31:20]};
  assign w_imm_s = {{(XLEN-12){Instr_D[31]}}, Instr_D[31:25], Instr_D[11:7]};
  assign w_imm_b = {{(XLEN-13){Instr_D[31]}}, Instr_D[31], Instr_D[7], Instr_D[30:25], Instr_D[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-32){Instr_D[31]}}, Instr_D[31:12], 12'h000};
  assign w_imm_j = {{(XLEN-21){Instr_D[31]}}, Instr_D[31], Instr_D[19:12], Instr_D[20], Instr_D[30:21], 1'b0};

  // Shared R/I arithmetic decode; is_r enables SUB, which has no immediate form.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f7b5, input logic is_r);
    case (f3)
      3'b000:  alu_op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  always_comb begin
    REG_W_En_D       = 1'b0;
    MEM_W_En_D       = 1'b0;
    Jump_En_D        = 1'b0;
    Branch_En_D      = 1'b0;
    MEM_Control_D    = 3'b000;
    ALU_Control_D    = ALU_ADD;
    Branch_Src_Sel_D = 1'b0;
    ALU_SrcA_Sel_D   = 1'b0;
    ALU_SrcB_Sel_D   = 1'b0;
    Result_Src_Sel_D = 2'b00;
    Imm_Ext_D        = '0;
    case (w_op)
      OP_R: begin
        REG_W_En_D    = 1'b1;
        ALU_Control_D = alu_op(w_f3, w_f7b5, 1'b1);
      end
      OP_I: begin
        REG_W_En_D     = 1'b1;
        ALU_SrcB_Sel_D = 1'b1;
        ALU_Control_D  = alu_op(w_f3, w_f7b5, 1'b0);
        Imm_Ext_D      = w_imm_i;
      end
      OP_LOAD: begin
        REG_W_En_D       = 1'b1;
        ALU_SrcB_Sel_D   = 1'b1;
        Result_Src_Sel_D = 2'b01;
        MEM_Control_D    = w_f3;
        Imm_Ext_D        = w_imm_i;
      end
      OP_STORE: begin
        MEM_W_En_D     = 1'b1;
        ALU_SrcB_Sel_D = 1'b1;
        MEM_Control_D  = w_f3;
        Imm_Ext_D      = w_imm_s;
      end
      OP_BRANCH: begin
        // funct3 010/011 are not branches; they fall through as a NOP.
        case (w_f3)
          3'b000: begin Branch_En_D = 1'b1; ALU_Control_D = ALU_BEQ;  Imm_Ext_D = w_imm_b; end
          3'b001: begin Branch_En_D = 1'b1; ALU_Control_D = ALU_BNE;  Imm_Ext_D = w_imm_b; end
          3'b100: begin Branch_En_D = 1'b1; ALU_Control_D = ALU_SLT;  Imm_Ext_D = w_imm_b; end
          3'b101: begin Branch_En_D = 1'b1; ALU_Control_D = ALU_BGE;  Imm_Ext_D = w_imm_b; end
          3'b110: begin Branch_En_D = 1'b1; ALU_Control_D = ALU_SLTU; Imm_Ext_D = w_imm_b; end
          3'b111: begin Branch_En_D = 1'b1; ALU_Control_D = ALU_BGEU; Imm_Ext_D = w_imm_b; end
          default: ;
        endcase
      end
      OP_JAL: begin
        Jump_En_D        = 1'b1;
        REG_W_En_D       = 1'b1;
        Result_Src_Sel_D = 2'b10;
        Imm_Ext_D        = w_imm_j;
      end
      OP_JALR: begin
        Jump_En_D        = 1'b1;
        REG_W_En_D       = 1'b1;
        Result_Src_Sel_D = 2'b10;
        Branch_Src_Sel_D = 1'b1;
        Imm_Ext_D        = w_imm_i;
      end
      OP_LUI: begin
        REG_W_En_D     = 1'b1;
        ALU_SrcB_Sel_D = 1'b1;
        ALU_Control_D  = ALU_PASS;
        Imm_Ext_D      = w_imm_u;
      end
      OP_AUIPC: begin
        REG_W_En_D     = 1'b1;
        ALU_SrcA_Sel_D = 1'b1;
        ALU_SrcB_Sel_D = 1'b1;
        Imm_Ext_D      = w_imm_u;
      end
      default: ;
    endcase
  end

endmodule
